ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting queue entries (power of two, >= 2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 Port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port PCSrcE  input  1  redirect request (taken branch/jump) from EX.
REQ-006 Port PCTargetE  input  32  redirect target address.
REQ-007 Port mem_req  output  1  single-cycle instruction-memory request pulse.
REQ-008 Port mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-009 Port mem_ack  input  1  response strobe, in order, at least 1 cycle after its request.
REQ-010 Port mem_rdata  input  32  instruction word, valid while mem_ack=1.
REQ-011 Port InstrF  output  32  head-of-queue instruction for the IF stage.
REQ-012 Port PCF  output  32  address of InstrF.
REQ-013 Port valid_o  output  1  head entry valid.
REQ-014 Port ready_i  input  1  IF stage accepts head (driven as ~StallF).

Function
REQ-015 The block SHALL implement FSM states FETCH (no request outstanding), WAIT (one outstanding), DRAIN (outstanding response to discard).
REQ-016 At most one request SHALL be outstanding; mem_ack SHALL be ignored in FETCH.
REQ-017 mem_req SHALL be 1 iff (state=FETCH, or state=WAIT with mem_ack=1) and PCSrcE=0 and post-cycle occupancy < DEPTH, where post-cycle occupancy = count + push - pop.
REQ-018 On mem_ack in WAIT without redirect, {fetch_pc, mem_rdata} SHALL be pushed and fetch_pc SHALL advance by 4 (32-bit wrap); back-to-back requests give 1 instruction/cycle at latency 1.
REQ-019 State SHALL go WAIT on mem_req; WAIT->FETCH on mem_ack with no new request.
REQ-020 valid_o SHALL equal (count != 0); a pop occurs when valid_o and ready_i are both 1; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-021 When count = 0, InstrF and PCF SHALL be 0.
REQ-022 PCSrcE=1 SHALL have top priority: count cleared (valid_o=0 next cycle), fetch_pc loaded with {PCTargetE[31:2],2'b00}, any same-cycle pop or push discarded.
REQ-023 On redirect in WAIT without mem_ack, state SHALL go DRAIN; in DRAIN mem_req=0 until mem_ack, whose data is dropped, then FETCH.
REQ-024 On redirect coinciding with mem_ack, the data SHALL be dropped and state SHALL go FETCH; first target request issues the next cycle.
REQ-025 Redirect in DRAIN SHALL update fetch_pc and remain in DRAIN.

Reset
REQ-026 Asserting reset SHALL immediately force state=FETCH, fetch_pc=RESET_PC, count=0, valid_o=0, InstrF=0, PCF=0, mem_req=0.
REQ-027 The first mem_req (addr RESET_PC) SHALL occur in the first cycle after reset deasserts; reset mid-WAIT/DRAIN abandons the outstanding request and any later stray mem_ack is ignored.

Configuration
REQ-028 Macro IFQ_BYPASS_EN defined: with count=0 and mem_ack in WAIT without redirect, valid_o SHALL be 1 that cycle with InstrF=mem_rdata, PCF=fetch_pc, and the entry SHALL not be pushed if ready_i=1.
REQ-029 Macro IFQ_BYPASS_EN undefined: valid_o SHALL assert no earlier than the cycle after the corresponding mem_ack.

Verification
REQ-030 Reset release, RESET_PC=0, latency 1, ready_i=1 -> mem_addr 0x0,0x4,0x8 on consecutive cycles; PCF 0x0,0x4,0x8 in order; first valid_o 2 cycles after first mem_req (1 with IFQ_BYPASS_EN).
REQ-031 ready_i=0, DEPTH=4 -> exactly 4 pushes, then mem_req=0, PCF held 0x0; ready_i=1 -> PCF 0x0,0x4,0x8,0xC and next mem_addr=0x10.
REQ-032 PCSrcE=1, PCTargetE=0x103 while fetch of 0x8 is outstanding, ack 3 cycles later -> ack dropped, mem_req=0 in DRAIN, next mem_addr=0x100, first PCF after redirect=0x100.
REQ-033 PCSrcE=1 in same cycle as mem_ack -> data dropped, valid_o=0 next cycle, mem_req with mem_addr=0x100 next cycle.
REQ-034 reset asserted during WAIT -> outputs 0 in the same cycle, stray mem_ack ignored, first post-reset mem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus bundle: EX redirect, instruction-memory request/response, IF-stage head port.
// The master modport is the fetch queue's view; slave is the surrounding pipeline/memory view.
interface ifetch_queue_if;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        valid_o;
  logic        ready_i;

  modport master (
    input  PCSrcE, PCTargetE, mem_ack, mem_rdata, ready_i,
    output mem_req, mem_addr, InstrF, PCF, valid_o
  );

  modport slave (
    output PCSrcE, PCTargetE, mem_ack, mem_rdata, ready_i,
    input  mem_req, mem_addr, InstrF, PCF, valid_o
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one outstanding word fetch at a time, buffers returned
// instructions in a DEPTH-entry FIFO, and flushes on an EX-stage redirect.
// Optional feature: define IFQ_BYPASS_EN to present a response directly on the head port
// when the queue is empty (saves one cycle of fetch latency).
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            CLK,
  input logic            reset,
  ifetch_queue_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StFetch, StWait, StDrain} stateT;

  stateT           stateQ, stateD;
  logic [31:0]     fetchPcQ, fetchPcD;
  logic [CntW-1:0] countQ, countD;
  logic [PtrW-1:0] rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [31:0]     pcMem    [DEPTH];
  logic [31:0]     instrMem [DEPTH];

  logic            qEmpty;
  logic            ackInWait;
  logic            takeAck;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            memReq;
  logic [CntW-1:0] postCount;

  assign qEmpty    = (countQ == '0);
  assign ackInWait = (stateQ == StWait) && bus.mem_ack;
  // A response is only kept when no redirect lands in the same cycle.
  assign takeAck   = ackInWait && !bus.PCSrcE;

`ifdef IFQ_BYPASS_EN
  assign bypass = takeAck && qEmpty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed by IF this cycle never enters the FIFO.
  assign pop       = !qEmpty && bus.ready_i;
  assign push      = takeAck && !(bypass && bus.ready_i);
  assign postCount = countQ + CntW'(push) - CntW'(pop);

  // Request when idle, or chain straight behind an arriving response, if room remains.
  assign memReq = !reset && ((stateQ == StFetch) || ackInWait) && !bus.PCSrcE &&
                  (postCount < CntFull);

  assign bus.mem_req  = memReq;
  assign bus.mem_addr = ackInWait ? (fetchPcQ + 32'd4) : fetchPcQ;
  assign bus.valid_o  = !qEmpty || bypass;
  assign bus.PCF      = !qEmpty ? pcMem[rdPtrQ]    : (bypass ? fetchPcQ      : 32'h0);
  assign bus.InstrF   = !qEmpty ? instrMem[rdPtrQ] : (bypass ? bus.mem_rdata : 32'h0);

  // Next-state: redirect overrides every push/pop; otherwise track FIFO and request state.
  always_comb begin
    stateD   = stateQ;
    fetchPcD = fetchPcQ;
    countD   = countQ;
    rdPtrD   = rdPtrQ;
    wrPtrD   = wrPtrQ;
    if (bus.PCSrcE) begin
      fetchPcD = {bus.PCTargetE[31:2], 2'b00};
      countD   = '0;
      rdPtrD   = '0;
      wrPtrD   = '0;
      // An unanswered request must still be absorbed before fetching the target.
      if (stateQ != StFetch) begin
        stateD = bus.mem_ack ? StFetch : StDrain;
      end
    end else begin
      countD = postCount;
      if (push) wrPtrD = wrPtrQ + PtrW'(1);
      if (pop) rdPtrD = rdPtrQ + PtrW'(1);
      if (takeAck) fetchPcD = fetchPcQ + 32'd4;
      case (stateQ)
        StFetch: if (memReq) stateD = StWait;
        StWait:  if (bus.mem_ack) stateD = memReq ? StWait : StFetch;
        StDrain: if (bus.mem_ack) stateD = StFetch;
        default: stateD = StFetch;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stateQ   <= StFetch;
      fetchPcQ <= RESET_PC;
      countQ   <= '0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
    end else begin
      stateQ   <= stateD;
      fetchPcQ <= fetchPcD;
      countQ   <= countD;
      rdPtrQ   <= rdPtrD;
      wrPtrQ   <= wrPtrD;
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge CLK) begin
    if (push) begin
      pcMem[wrPtrQ]    <= fetchPcQ;
      instrMem[wrPtrQ] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model and an in-order single-outstanding memory model.
module tb_ifetch_queue;

  localparam int          Depth   = 4;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(Depth), .RESET_PC(ResetPc)) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state.
  logic [63:0] mq[$];       // {pc, instr} expected in the queue, head first
  bit          outst;       // a live-or-killed request is outstanding at memory
  bit          killed;      // the outstanding response must be dropped
  int          waitCnt;     // cycles left before the memory answers
  int          latMin, latMax;
  bit          forceStray;  // drive mem_ack with nothing outstanding
  logic [31:0] expAddr;     // next address the queue must fetch
  logic [31:0] outAddr;     // address of the outstanding request

  // Values sampled in the last step, for directed checks.
  bit          sReq, sValid;
  logic [31:0] sAddr, sPcf, sInstr;

  task automatic model_clear();
    mq.delete();
    outst   = 1'b0;
    killed  = 1'b0;
    waitCnt = 0;
    expAddr = ResetPc;
    outAddr = ResetPc;
  endtask

  task automatic drive_idle();
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = 32'h0;
    bus.ready_i   = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  // Entered at posedge+1; leaves at the next posedge+1. Checks one cycle against the model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy);
    bit          ackNow, byp, expValid, expReq;
    int          pushN, popN;
    logic [31:0] rd;
    logic [63:0] head;
    ackNow        = outst && (waitCnt == 0);
    rd            = $urandom;
    bus.PCSrcE    = redir;
    bus.PCTargetE = tgt;
    bus.ready_i   = rdy;
    bus.mem_ack   = ackNow || forceStray;
    bus.mem_rdata = rd;
    @(negedge CLK);
    sReq   = bus.mem_req;
    sValid = bus.valid_o;
    sAddr  = bus.mem_addr;
    sPcf   = bus.PCF;
    sInstr = bus.InstrF;

    byp = Bypass && (mq.size() == 0) && ackNow && !killed && !redir;
    expValid = (mq.size() != 0) || byp;
    if (mq.size() != 0) head = mq[0];
    else if (byp) head = {outAddr, rd};
    else head = 64'h0;

    nChecks++;
    if (sValid !== expValid) begin
      nFails++;
      $display("FAIL model valid_o @%0t: got %0b expected %0b", $time, sValid, expValid);
    end
    nChecks++;
    if ({sPcf, sInstr} !== head) begin
      nFails++;
      $display("FAIL model head @%0t: got PCF=%h InstrF=%h expected PCF=%h InstrF=%h",
               $time, sPcf, sInstr, head[63:32], head[31:0]);
    end

    popN   = ((mq.size() != 0) && rdy) ? 1 : 0;
    pushN  = (ackNow && !killed && !redir && !(byp && rdy)) ? 1 : 0;
    expReq = !redir && (!outst || (ackNow && !killed)) && ((mq.size() + pushN - popN) < Depth);
    nChecks++;
    if (sReq !== expReq) begin
      nFails++;
      $display("FAIL model mem_req @%0t: got %0b expected %0b", $time, sReq, expReq);
    end
    if (sReq && expReq) begin
      nChecks++;
      if (sAddr !== expAddr) begin
        nFails++;
        $display("FAIL model mem_addr @%0t: got %h expected %h", $time, sAddr, expAddr);
      end
    end

    // Advance model to the state after this clock edge.
    if (outst && !ackNow) waitCnt--;
    if (redir) begin
      mq.delete();
      expAddr = {tgt[31:2], 2'b00};
      if (outst && !ackNow) killed = 1'b1;
      else begin
        outst  = 1'b0;
        killed = 1'b0;
      end
    end else begin
      if (popN != 0) void'(mq.pop_front());
      if (ackNow) begin
        if (pushN != 0) mq.push_back({outAddr, rd});
        outst  = 1'b0;
        killed = 1'b0;
      end
      if (sReq) begin
        outst   = 1'b1;
        killed  = 1'b0;
        outAddr = expAddr;
        expAddr = expAddr + 32'd4;
        waitCnt = $urandom_range(latMax, latMin);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge CLK);
    #1;
    nChecks++;
    if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL reset mem_req: got %b expected 0", bus.mem_req); end
    nChecks++;
    if (bus.valid_o !== 1'b0) begin nFails++; $display("FAIL reset valid_o: got %b expected 0", bus.valid_o); end
    nChecks++;
    if (bus.PCF !== 32'h0) begin nFails++; $display("FAIL reset PCF: got %h expected 0", bus.PCF); end
    nChecks++;
    if (bus.InstrF !== 32'h0) begin nFails++; $display("FAIL reset InstrF: got %h expected 0", bus.InstrF); end
    reset = 1'b0;
    model_clear();
    latMin = 0;
    latMax = 0;
    step(1'b0, 32'h0, 1'b1);
    nChecks++;
    if (!(sReq === 1'b1 && sAddr === ResetPc)) begin
      nFails++;
      $display("FAIL first request after reset: got req=%b addr=%h expected req=1 addr=%h",
               sReq, sAddr, ResetPc);
    end
  endtask

  task automatic test_stream();
    int          reqCyc[$];
    logic [31:0] reqAddr[$];
    logic [31:0] pcs[$];
    int          firstValid;
    firstValid = -1;
    do_reset();
    latMin = 0;
    latMax = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (sReq) begin reqCyc.push_back(c); reqAddr.push_back(sAddr); end
      if (sValid) begin
        if (firstValid < 0) firstValid = c;
        pcs.push_back(sPcf);
      end
    end
    nChecks++;
    if (reqCyc.size() < 3 || pcs.size() < 3) begin
      nFails++;
      $display("FAIL stream counts: got %0d reqs %0d valids expected >=3 each", reqCyc.size(), pcs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nChecks++;
        if (reqCyc[i] != i || reqAddr[i] !== 32'(4 * i)) begin
          nFails++;
          $display("FAIL stream req %0d: got cycle %0d addr %h expected cycle %0d addr %h",
                   i, reqCyc[i], reqAddr[i], i, 4 * i);
        end
        nChecks++;
        if (pcs[i] !== 32'(4 * i)) begin
          nFails++;
          $display("FAIL stream PCF %0d: got %h expected %h", i, pcs[i], 4 * i);
        end
      end
    end
    nChecks++;
    if (firstValid != (Bypass ? 1 : 2)) begin
      nFails++;
      $display("FAIL stream first valid: got cycle %0d expected %0d", firstValid, Bypass ? 1 : 2);
    end
  endtask

  task automatic test_full();
    int          nReq;
    logic [31:0] pcs[$];
    logic [31:0] nextAddr;
    bit          gotReq;
    nReq   = 0;
    gotReq = 1'b0;
    do_reset();
    latMin = 0;
    latMax = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 32'h0, 1'b0);
      if (sReq) nReq++;
    end
    nChecks++;
    if (nReq != Depth) begin nFails++; $display("FAIL full req count: got %0d expected %0d", nReq, Depth); end
    nChecks++;
    if (sReq !== 1'b0 || sValid !== 1'b1 || sPcf !== 32'h0) begin
      nFails++;
      $display("FAIL full hold: got req=%b valid=%b PCF=%h expected req=0 valid=1 PCF=0",
               sReq, sValid, sPcf);
    end
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (sValid) pcs.push_back(sPcf);
      if (sReq && !gotReq) begin gotReq = 1'b1; nextAddr = sAddr; end
    end
    nChecks++;
    if (pcs.size() < 4) begin
      nFails++;
      $display("FAIL full drain count: got %0d expected >=4", pcs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if (pcs[i] !== 32'(4 * i)) begin
          nFails++;
          $display("FAIL full drain PCF %0d: got %h expected %h", i, pcs[i], 4 * i);
        end
      end
    end
    nChecks++;
    if (!gotReq || nextAddr !== 32'h10) begin
      nFails++;
      $display("FAIL full next addr: got seen=%b addr=%h expected 00000010", gotReq, nextAddr);
    end
  endtask

  task automatic test_redirect_drain();
    bit          found, gotReq, gotValid;
    int          reqK;
    logic [31:0] reqA, firstPc;
    found = 1'b0; gotReq = 1'b0; gotValid = 1'b0; reqK = -1;
    do_reset();
    latMin = 2;
    latMax = 2;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (sReq && sAddr === 32'h8) found = 1'b1;
    end
    nChecks++;
    if (!found) begin nFails++; $display("FAIL drain setup: got no fetch of 00000008 expected one"); end
    step(1'b1, 32'h103, 1'b1);
    nChecks++;
    if (sReq !== 1'b0) begin nFails++; $display("FAIL drain redirect req: got %b expected 0", sReq); end
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 32'h0, 1'b1);
      if (sReq && !gotReq) begin gotReq = 1'b1; reqK = k; reqA = sAddr; end
      if (sValid && !gotValid) begin gotValid = 1'b1; firstPc = sPcf; end
    end
    nChecks++;
    if (!gotReq || reqK != 2 || reqA !== 32'h100) begin
      nFails++;
      $display("FAIL drain target req: got cycle %0d addr %h expected cycle 2 addr 00000100", reqK, reqA);
    end
    nChecks++;
    if (!gotValid || firstPc !== 32'h100) begin
      nFails++;
      $display("FAIL drain first PCF: got valid=%b PCF=%h expected 00000100", gotValid, firstPc);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    latMin = 0;
    latMax = 0;
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h103, 1'b0);
    nChecks++;
    if (sReq !== 1'b0) begin nFails++; $display("FAIL redirect+ack req: got %b expected 0", sReq); end
    step(1'b0, 32'h0, 1'b0);
    nChecks++;
    if (sValid !== 1'b0 || sReq !== 1'b1 || sAddr !== 32'h100) begin
      nFails++;
      $display("FAIL redirect+ack next: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000100",
               sValid, sReq, sAddr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    latMin = 0;
    latMax = 0;
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b0);
    bus.PCSrcE    = 1'b0;
    bus.ready_i   = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2;
    reset = 1'b1;
    #1;
    nChecks++;
    if ({bus.mem_req, bus.valid_o} !== 2'b00 || bus.PCF !== 32'h0 || bus.InstrF !== 32'h0) begin
      nFails++;
      $display("FAIL mid-wait reset outputs: got req=%b valid=%b PCF=%h InstrF=%h expected all 0",
               bus.mem_req, bus.valid_o, bus.PCF, bus.InstrF);
    end
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_clear();
    forceStray = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    forceStray = 1'b0;
    nChecks++;
    if (sReq !== 1'b1 || sAddr !== ResetPc || sValid !== 1'b0) begin
      nFails++;
      $display("FAIL post-reset fetch: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
               sReq, sAddr, sValid, ResetPc);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    latMin = 0;
    latMax = 3;
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(11) == 0, $urandom, $urandom_range(3) != 0);
    end
  endtask

  initial begin
    forceStray = 1'b0;
    latMin = 0;
    latMax = 0;
    model_clear();
    drive_idle();
    test_reset();
    test_stream();
    test_full();
    test_redirect_drain();
    test_redirect_ack();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
